uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl_if.sv | 35 +++
 rtl/uart_tx_ctrl.sv | 105 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - payload/parity handshake and serial line bundle for uart_tx_ctrl
// Parity_type travels with the bundle for the external parity calculator; the controller never reads it.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  Data_Valid;
    logic                  Parity_EN;
    logic                  Parity_type;
    logic                  Parity_bit;
    logic                  Par_Valid;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_Data,
        output Data_Valid,
        output Parity_EN,
        output Parity_type,
        output Parity_bit,
        input  Par_Valid,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_Data,
        input  Data_Valid,
        input  Parity_EN,
        input  Parity_bit,
        output Par_Valid,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART frame serializer: start, LSB-first data, optional parity, stop bits
// One bit per clock; TX_OUT and Busy are registered, Par_Valid strobes the external parity calculator.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_ctrl_if.slave  tx_if
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  tx_q;
    logic                  busy_q;

    // The calculator captures parity of the same P_Data on the accept edge.
    assign tx_if.Par_Valid = rst_n && (state_q == IDLE) && tx_if.Data_Valid && tx_if.Parity_EN;
    assign tx_if.TX_OUT    = tx_q;
    assign tx_if.Busy      = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (tx_if.Data_Valid) begin
                        data_q   <= tx_if.P_Data;
                        par_en_q <= tx_if.Parity_EN;
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    // The payload register shifts out LSB first; bit 0 is always at data_q[0].
                    state_q <= DATA;
                    cnt_q   <= '0;
                    tx_q    <= data_q[0];
                    data_q  <= data_q >> 1;
                end
                DATA: begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_q <= '0;
                        if (par_en_q) begin
                            state_q <= PARITY;
                            tx_q    <= tx_if.Parity_bit;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        tx_q   <= data_q[0];
                        data_q <= data_q >> 1;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_q == LAST_STOP) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl with one- and two-stop-bit instances
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    typedef struct packed {
        logic [15:0] bits;
        logic [4:0]  len;
        logic        pv;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] p_data [2];
    logic          dv     [2];
    logic          pen    [2];
    logic          ptype  [2];
    logic          pbit   [2];
    logic          pv     [2];
    logic          tx     [2];
    logic          busy   [2];

    int checks   = 0;
    int failures = 0;

    frame_t exp_q [2][$];

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) if0 ();
    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) if1 ();

    assign if0.P_Data      = p_data[0];
    assign if0.Data_Valid  = dv[0];
    assign if0.Parity_EN   = pen[0];
    assign if0.Parity_type = ptype[0];
    assign if0.Parity_bit  = pbit[0];
    assign pv[0]           = if0.Par_Valid;
    assign tx[0]           = if0.TX_OUT;
    assign busy[0]         = if0.Busy;

    assign if1.P_Data      = p_data[1];
    assign if1.Data_Valid  = dv[1];
    assign if1.Parity_EN   = pen[1];
    assign if1.Parity_type = ptype[1];
    assign if1.Parity_bit  = pbit[1];
    assign pv[1]           = if1.Par_Valid;
    assign tx[1]           = if1.TX_OUT;
    assign busy[1]         = if1.Busy;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut0 (.clk(clk), .rst_n(rst_n), .tx_if(if0));
    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut1 (.clk(clk), .rst_n(rst_n), .tx_if(if1));

    // External parity calculator: registered, captures on the Par_Valid strobe.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) pbit[k] <= 1'b0;
            else if (pv[k]) pbit[k] <= (^p_data[k]) ^ ptype[k];
        end
    end

    function automatic int stops(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Reference frame: the serial bit sequence the line must carry, bit j = j-th bit on the wire.
    function automatic frame_t model(int k, logic [7:0] d, logic pe, logic pt);
        frame_t f;
        int n;
        f.bits = '0;
        n = 0;
        f.bits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < DW; i++) begin
            f.bits[n] = d[i];
            n = n + 1;
        end
        if (pe) begin
            f.bits[n] = (^d) ^ pt;
            n = n + 1;
        end
        for (int s = 0; s < stops(k); s++) begin
            f.bits[n] = 1'b1;
            n = n + 1;
        end
        f.len = 5'(n);
        f.pv  = pe;
        return f;
    endfunction

    task automatic chk(string name, int act, int req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    logic [15:0] coll  [2];
    int          clen  [2];
    int          pvc   [2];
    logic        bprev [2];
    frame_t      mon_e;
    logic [15:0] mon_mask;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                coll[k]  = '0;
                clen[k]  = 0;
                pvc[k]   = 0;
                bprev[k] = 1'b0;
            end else begin
                if (busy[k]) begin
                    if (clen[k] < 16) coll[k][clen[k]] = tx[k];
                    clen[k] = clen[k] + 1;
                end else if (bprev[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("dut%0d_unexpected_frame", k), 1, 0);
                    end else begin
                        mon_e    = exp_q[k].pop_front();
                        mon_mask = 16'((17'd1 << mon_e.len) - 17'd1);
                        chk($sformatf("dut%0d_busy_cycles", k), clen[k], int'(mon_e.len));
                        chk($sformatf("dut%0d_frame_bits", k), int'(coll[k] & mon_mask), int'(mon_e.bits));
                        chk($sformatf("dut%0d_par_valid_pulses", k), pvc[k], int'(mon_e.pv));
                        chk($sformatf("dut%0d_idle_line", k), int'(tx[k]), 1);
                    end
                    coll[k] = '0;
                    clen[k] = 0;
                    pvc[k]  = 0;
                end
                if (pv[k]) pvc[k] = pvc[k] + 1;
                bprev[k] = busy[k];
            end
        end
    end

    task automatic wait_idle(int k);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[k] && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 200) chk($sformatf("dut%0d_idle_timeout", k), 1, 0);
    endtask

    task automatic send(int k, logic [7:0] d, logic pe, logic pt, bit spur);
        int len;
        int r;
        wait_idle(k);
        p_data[k] = d;
        pen[k]    = pe;
        ptype[k]  = pt;
        dv[k]     = 1'b1;
        exp_q[k].push_back(model(k, d, pe, pt));
        @(posedge clk);
        @(negedge clk);
        dv[k]     = 1'b0;
        p_data[k] = 8'($urandom);
        pen[k]    = 1'($urandom_range(0, 1));
        ptype[k]  = 1'($urandom_range(0, 1));
        if (spur) begin
            len = 1 + DW + int'(pe) + stops(k);
            r   = $urandom_range(0, len - 2);
            repeat (r) @(negedge clk);
            dv[k]     = 1'b1;
            pen[k]    = 1'b1;
            p_data[k] = 8'($urandom);
            @(negedge clk);
            dv[k] = 1'b0;
        end
    endtask

    initial begin
        logic pe;
        logic pt;
        int   n;
        for (int k = 0; k < 2; k++) begin
            p_data[k] = '0;
            dv[k]     = 1'b0;
            pen[k]    = 1'b0;
            ptype[k]  = 1'b0;
        end
        rst_n  = 1'b0;
        dv[0]  = 1'b1;
        pen[0] = 1'b1;
        #12;
        chk("reset_tx0", int'(tx[0]), 1);
        chk("reset_busy0", int'(busy[0]), 0);
        chk("reset_par_valid0", int'(pv[0]), 0);
        chk("reset_tx1", int'(tx[1]), 1);
        chk("reset_busy1", int'(busy[1]), 0);
        dv[0]  = 1'b0;
        pen[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send(1, 8'h01, 1'b1, 1'b1, 1'b0);
        send(1, 8'hC3, 1'b0, 1'b1, 1'b1);

        // Data_Valid held high across two frames, P_Data changed mid-frame.
        pe = 1'($urandom_range(0, 1));
        pt = 1'($urandom_range(0, 1));
        wait_idle(0);
        p_data[0] = 8'h3C;
        pen[0]    = pe;
        ptype[0]  = pt;
        dv[0]     = 1'b1;
        exp_q[0].push_back(model(0, 8'h3C, pe, pt));
        @(posedge clk);
        @(negedge clk);
        p_data[0] = 8'h55;
        exp_q[0].push_back(model(0, 8'h55, pe, pt));
        n = 0;
        while (busy[0] && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("held_valid_gap_seen", int'(n < 100), 1);
        @(posedge clk);
        @(negedge clk);
        dv[0] = 1'b0;

        // Reset during data bit 3 of 0xA5, new request waiting at release.
        wait_idle(1);
        wait_idle(0);
        p_data[0] = 8'hA5;
        pen[0]    = 1'b1;
        ptype[0]  = 1'b0;
        dv[0]     = 1'b1;
        exp_q[0].push_back(model(0, 8'hA5, 1'b1, 1'b0));
        @(posedge clk);
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        p_data[0] = 8'h0F;
        pen[0]    = 1'b1;
        ptype[0]  = 1'b0;
        dv[0]     = 1'b1;
        #1;
        chk("async_reset_tx", int'(tx[0]), 1);
        chk("async_reset_busy", int'(busy[0]), 0);
        chk("reset_par_valid_gated", int'(pv[0]), 0);
        exp_q[0].delete();
        exp_q[0].push_back(model(0, 8'h0F, 1'b1, 1'b0));
        #13 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("accept_first_edge_after_reset", int'(busy[0]), 1);
        @(negedge clk);
        dv[0] = 1'b0;

        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 1), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        chk("dut0_queue_drained", exp_q[0].size(), 0);
        chk("dut1_queue_drained", exp_q[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
